// File: rtl/sync_fifo_write_arb.sv
// sync_fifo_write_arb
// Round-robin arbiter that funnels NUM_REQ requesters into one sync_fifo
// write port. Each write is a single WRITE cycle followed by GAP_CYCLES idle
// HOLDOFF cycles so the downstream crossing can settle.
//
// Optional feature: define SYNC_FIFO_ARB_PRIORITY_EN to give requester 0
// absolute priority; the remaining requesters keep round-robin among
// themselves and requester-0 grants do not move the round-robin pointer.
module sync_fifo_write_arb #(
    parameter int WIDTH      = 32,
    parameter int NUM_REQ    = 4,
    parameter int GAP_CYCLES = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         ack,
    output logic                       write_en,
    output logic [WIDTH-1:0]           data_out,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
);

    localparam int IDW = $clog2(NUM_REQ);

    // Pointer starts at the top so requester 0 is searched first after reset.
    localparam logic [IDW-1:0] LAST_RST = IDW'(NUM_REQ - 1);

    // Terminal HOLDOFF count; unused when GAP_CYCLES==0 (HOLDOFF unreachable).
    localparam logic [7:0] GAP_LAST = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IDW-1:0]  last_grant;
    logic [IDW-1:0]  win_id;
    logic            win_vld;
    logic [7:0]      hold_cnt;

    // First set candidate strictly after 'last', wrapping around.
    function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] cand,
                                                input logic [IDW-1:0]     last);
        logic [IDW-1:0] pick;
        logic           found;
        int             idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (!found && cand[IDW'(idx)]) begin
                found = 1'b1;
                pick  = IDW'(idx);
            end
        end
        return pick;
    endfunction

    // Winner selection over the live request vector.
    always_comb begin
        win_vld = |req;
        win_id  = '0;
`ifdef SYNC_FIFO_ARB_PRIORITY_EN
        if (req[0]) begin
            win_id = '0;
        end else begin
            win_id = rr_pick({req[NUM_REQ-1:1], 1'b0}, last_grant);
        end
`else
        win_id = rr_pick(req, last_grant);
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: one WRITE cycle, then GAP_CYCLES of HOLDOFF.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (win_vld) state_nxt = WRITE;
            WRITE:   state_nxt = (GAP_CYCLES == 0) ? IDLE : HOLDOFF;
            HOLDOFF: if (hold_cnt == GAP_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // HOLDOFF cycle counter; zero whenever not in HOLDOFF.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt <= '0;
        end else if (state == HOLDOFF && state_nxt == HOLDOFF) begin
            hold_cnt <= hold_cnt + 8'd1;
        end else begin
            hold_cnt <= '0;
        end
    end

    // Latch the winner's word and id on the grant edge; held until next grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out <= '0;
            grant_id <= '0;
        end else if (state == IDLE && win_vld) begin
            data_out <= req_data[int'(win_id)*WIDTH +: WIDTH];
            grant_id <= win_id;
        end
    end

    // Round-robin pointer advances as the write completes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= LAST_RST;
        end else if (state == WRITE) begin
`ifdef SYNC_FIFO_ARB_PRIORITY_EN
            if (grant_id != '0) last_grant <= grant_id;
`else
            last_grant <= grant_id;
`endif
        end
    end

    // Moore outputs straight off the state register so reset kills them at once.
    assign write_en = (state == WRITE);
    assign busy     = (state != IDLE);

    // Per-requester ack decode.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_ack
        assign ack[i] = write_en && (grant_id == IDW'(i));
    end

endmodule

// File: tb/tb_sync_fifo_write_arb.sv
// Scoreboard bench for sync_fifo_write_arb (WIDTH=32, NUM_REQ=4, GAP_CYCLES=4).
module tb_sync_fifo_write_arb;
    localparam int W = 32;
    localparam int N = 4;
    localparam int G = 4;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [N-1:0]       req;
    logic [N*W-1:0]     req_data;
    logic [N-1:0]       ack;
    logic               write_en;
    logic [W-1:0]       data_out;
    logic [1:0]         grant_id;
    logic               busy;

    typedef struct {
        int         id;
        logic [W-1:0] data;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_wr = -1;
    int writes_seen = 0;
    int busy_cyc = 0;
    bit gap_en = 1'b0;

    sync_fifo_write_arb #(.WIDTH(W), .NUM_REQ(N), .GAP_CYCLES(G)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .write_en (write_en),
        .data_out (data_out),
        .grant_id (grant_id),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int id, input logic [W-1:0] d);
        exp_t e;
        e.id   = id;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Monitor: compare every write against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (busy) busy_cyc++;
        if (write_en) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 64'(grant_id), 64'hFF);
            end else begin
                e = exp_q.pop_front();
                chk("data_out", 64'(data_out), 64'(e.data));
                chk("ack",      64'(ack),      64'(4'b0001 << e.id));
                chk("grant_id", 64'(grant_id), 64'(e.id));
            end
            if (gap_en && last_wr >= 0) chk("write_gap", 64'(cyc - last_wr), 64'(G + 2));
            last_wr = cyc;
            writes_seen++;
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic wait_writes(input int target, input int budget);
        int n;
        n = 0;
        while (writes_seen < target && n < budget) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("write_count", 64'(writes_seen), 64'(target));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(2);
        last_wr = -1;
        reset_n = 1'b1;
    endtask

    initial begin
        int base;
        reset_n  = 1'b0;
        req      = '0;
        req_data = '0;
        tick(2);

        // Reset state
        chk("rst_write_en", 64'(write_en), 0);
        chk("rst_ack",      64'(ack),      0);
        chk("rst_busy",     64'(busy),     0);
        chk("rst_data_out", 64'(data_out), 0);
        chk("rst_grant_id", 64'(grant_id), 0);
        reset_n = 1'b1;
        tick(1);

        // Single request from requester 1; busy for 1+G cycles
        gap_en   = 1'b0;
        busy_cyc = 0;
        req      = 4'b0010;
        req_data[1*W +: W] = 32'hAABBCCDD;
        push(1, 32'hAABBCCDD);
        base = writes_seen;
        tick(1);
        req = '0;
        wait_writes(base + 1, 4);
        tick(10);
        chk("busy_cycles", 64'(busy_cyc), 64'(G + 1));
        chk("data_hold", 64'(data_out), 64'hAABBCCDD);

        // All four requesting continuously
        req = 4'b1111;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = 32'h1111_1111 * (i + 1);
        do_reset();
        gap_en = 1'b1;
`ifdef SYNC_FIFO_ARB_PRIORITY_EN
        for (int k = 0; k < 5; k++) push(0, 32'h1111_1111);
`else
        push(0, 32'h1111_1111);
        push(1, 32'h2222_2222);
        push(2, 32'h3333_3333);
        push(3, 32'h4444_4444);
        push(0, 32'h1111_1111);
`endif
        base = writes_seen;
        wait_writes(base + 5, 40);
        req = '0;
        tick(10);
        gap_en = 1'b0;

        // req[2] held, req[0] only pulsed while in HOLDOFF: never granted
        req = 4'b0000;
        req_data[2*W +: W] = 32'hC0DE_0002;
        req_data[0*W +: W] = 32'hBAD0_0000;
        do_reset();
        gap_en = 1'b1;
        req = 4'b0100;
        for (int k = 0; k < 3; k++) push(2, 32'hC0DE_0002);
        base = writes_seen;
        for (int k = 0; k < 3; k++) begin
            wait_writes(base + k + 1, 12);
            tick(1);
            req[0] = 1'b1;
            tick(2);
            chk("holdoff_busy", 64'(busy), 1);
            tick(1);
            req[0] = 1'b0;
        end
        req = '0;
        tick(10);
        gap_en = 1'b0;

        // Reset during WRITE drops the write at once; requester 0 first after release
        req_data[2*W +: W] = 32'h5A5A_5A5A;
        do_reset();
        req = 4'b0100;
        push(2, 32'h5A5A_5A5A);
        base = writes_seen;
        wait_writes(base + 1, 4);
        reset_n = 1'b0;
        #1;
        chk("rstw_write_en", 64'(write_en), 0);
        chk("rstw_ack",      64'(ack),      0);
        chk("rstw_data_out", 64'(data_out), 0);
        chk("rstw_busy",     64'(busy),     0);
        req = 4'b0001;
        req_data[0*W +: W] = 32'h0000_0C0D;
        push(0, 32'h0000_0C0D);
        tick(1);
        reset_n = 1'b1;
        wait_writes(base + 2, 4);
        req = '0;
        tick(10);

        chk("scoreboard_empty", 64'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d expected 0", 1);
        $fatal(1);
    end
endmodule
